// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared types and constants for the servo pose sequencer:
//               sequencer state encoding, command field widths and the
//               millisecond prescale helper.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

    localparam int LOC_W = 16;  // servo target position width
    localparam int ID_W  = 8;   // servo ID width

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Clock cycles per millisecond.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ============================================================================
// Module      : ms_timer
// Description : Millisecond timer. A prescaler counts 0..TICK_DIV-1 and each
//               wrap advances a 16-bit ms counter that saturates at 16'hFFFF.
//               A clear has priority over counting.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               clear  - synchronous clear of prescaler and ms counter
//               ms_cnt - elapsed milliseconds since the last clear
// Revision    : 1.0 - initial release
// ============================================================================
module ms_timer #(
    parameter int TICK_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    output logic [15:0] ms_cnt
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [15:0]   r_ms;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (clear) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (r_presc == C_PRESC_MAX) begin
            r_presc <= '0;
            if (r_ms != 16'hFFFF) begin
                r_ms <= r_ms + 16'd1;
            end
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign ms_cnt = r_ms;

endmodule
`default_nettype wire

// File: rtl/servo_pose_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : servo_pose_sequencer
// Description : Snapshots NUM_CH joint targets on a start edge and issues one
//               command per joint to the servo serializer over a pulse/done
//               handshake, with a programmable ms gap between commands,
//               selectable joint order, abort, busy and a sticky timeout.
// Ports       : sys_clk, sys_rst_n      - clock, async active-low reset
//               start_i                 - async start level (rising edge)
//               abort_i                 - synchronous level abort
//               dir_i                   - 1 = slot 0 first, 0 = last slot first
//               gap_ms_i                - inter-command gap in ms
//               locations_i             - packed targets, slot k at [16k+15:16k]
//               cmd_en/cmd_id/cmd_location/cmd_done - serializer handshake
//               busy, send_finish, timeout_err      - status
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pose_sequencer
    import servo_pkg::*;
#(
    parameter int              NUM_CH     = 5,
    parameter int              CLK_HZ     = 50_000_000,
    parameter logic [ID_W-1:0] ID_BASE    = 8'h01,
    parameter int              TIMEOUT_MS = 100
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    dir_i,
    input  logic [15:0]             gap_ms_i,
    input  logic [LOC_W*NUM_CH-1:0] locations_i,
    output logic                    cmd_en,
    output logic [ID_W-1:0]         cmd_id,
    output logic [LOC_W-1:0]        cmd_location,
    input  logic                    cmd_done,
    output logic                    busy,
    output logic                    send_finish,
    output logic                    timeout_err
);

    localparam int TICK_DIV = (tick_div(CLK_HZ) < 1) ? 1 : tick_div(CLK_HZ);
    localparam int POS_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [POS_W-1:0] C_LAST_POS = POS_W'(NUM_CH - 1);

    state_t r_state;
    state_t w_next;

    logic r_sync1, r_sync2, r_start_d, r_start_pulse;
    logic w_accept, w_advance, w_set_to, w_clear;
    logic w_last;

    logic [POS_W-1:0]        r_pos;
    logic [POS_W-1:0]        w_slot;
    logic                    r_dir;
    logic [15:0]             r_gap;
    logic [LOC_W*NUM_CH-1:0] r_locs;
    logic [ID_W-1:0]         r_cmd_id;
    logic [LOC_W-1:0]        r_cmd_loc;
    logic                    r_timeout_err;
    logic [15:0]             w_ms_cnt;

    // Start synchroniser and edge detect. The edge is registered into a
    // one-cycle pulse so IDLE sees a clean, glitch-free request.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_start_d     <= 1'b0;
            r_start_pulse <= 1'b0;
        end else begin
            r_sync1       <= start_i;
            r_sync2       <= r_sync1;
            r_start_d     <= r_sync2;
            r_start_pulse <= r_sync2 & ~r_start_d;
        end
    end

    assign w_last = (r_pos == C_LAST_POS);
    assign w_slot = r_dir ? r_pos : (C_LAST_POS - r_pos);

    ms_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .clear  (w_clear),
        .ms_cnt (w_ms_cnt)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_advance = 1'b0;
        w_set_to  = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start_pulse) begin
                    w_accept = 1'b1;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: w_next = S_SEND;
            S_SEND: begin
                w_clear = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the same cycle as the limit still counts.
                if (cmd_done) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_clear = 1'b1;
                        w_next  = S_GAP;
                    end
                end else if (w_ms_cnt >= 16'(TIMEOUT_MS)) begin
                    w_set_to = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_ms_cnt == r_gap) begin
                    w_advance = 1'b1;
                    w_next    = S_LOAD;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Abort overrides everything, including a coincident cmd_done.
        if (abort_i && (r_state != S_IDLE)) begin
            w_next    = S_IDLE;
            w_advance = 1'b0;
            w_set_to  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pos         <= '0;
            r_dir         <= 1'b0;
            r_gap         <= '0;
            r_locs        <= '0;
            r_cmd_id      <= '0;
            r_cmd_loc     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pos         <= '0;
                r_dir         <= dir_i;
                r_gap         <= gap_ms_i;
                r_locs        <= locations_i;
                r_timeout_err <= 1'b0;
            end
            if (w_advance) begin
                r_pos <= r_pos + POS_W'(1);
            end
            if (w_set_to) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_cmd_id  <= ID_BASE + ID_W'(w_slot);
                r_cmd_loc <= r_locs[int'(w_slot)*LOC_W +: LOC_W];
            end
        end
    end

    assign cmd_en       = (r_state == S_SEND);
    assign send_finish  = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign cmd_id       = r_cmd_id;
    assign cmd_location = r_cmd_loc;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire
